nap_countdown: RTL

//  Downstream of the keypad time-select stage. Loads the BCD nap duration (one_min:ten_sec:one_sec)
//  on the rising edge of timer_en and counts it down at 1 Hz to 0:00.
//  At 0:00 it raises alarm for ALARM_SEC seconds and pulses done.

---
 rtl/nap_pkg.sv | 34 +++
 rtl/nap_tick_gen.sv | 47 ++++
 rtl/nap_countdown.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/nap_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : nap_pkg
//  Description : Shared types and constants for the nap timer pipeline
//                (keypad select, countdown, display). Holds the countdown
//                state encoding, the BCD digit type, the per-digit limits of
//                an M:SS display and a digit clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package nap_pkg;

  // One BCD digit.
  typedef logic [3:0] bcd_t;

  // Countdown controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } nap_state_t;

  // Largest legal value of each displayed digit (M:SS, max 9:59).
  localparam bcd_t SEC_ONE_MAX = 4'd9;
  localparam bcd_t SEC_TEN_MAX = 4'd5;
  localparam bcd_t MIN_MAX     = 4'd9;

  // Saturate a digit to its legal maximum (non-BCD codes land on the limit).
  function automatic bcd_t clamp_digit(input bcd_t digit, input bcd_t limit);
    return (digit > limit) ? limit : digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nap_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nap_tick_gen
//  Description : One-second prescaler. Counts clock cycles while 'run' is
//                high and emits a single-cycle 'tick' on the cycle where the
//                count wraps from CLK_HZ-1 to 0. Holds its count while 'run'
//                is low so a frozen countdown resumes mid-second.
//  Ports       : clock - system clock (posedge)
//                reset - asynchronous active-high reset, clears the count
//                run   - advance the prescaler this cycle
//                clear - force the count to 0 (wins over run, no tick)
//                tick  - combinational, high on the wrapping cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module nap_tick_gen #(
  parameter int CLK_HZ = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  // A 1 Hz clock would give $clog2(1)=0; keep at least one bit.
  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] count;
  logic             at_term;

  assign at_term = (count == TERM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= at_term ? '0 : count + CNT_W'(1);
    end
  end

  assign tick = run & ~clear & at_term;

endmodule
`default_nettype wire

// File: rtl/nap_countdown.sv
`default_nettype none
// ============================================================================
//  Module      : nap_countdown
//  Description : Nap timer countdown. Loads a clamped BCD duration (M:SS) on
//                the rising edge of timer_en, counts it down at 1 Hz, then
//                holds alarm high for ALARM_SEC seconds. done pulses for one
//                cycle on entry to the alarm phase. Dropping timer_en aborts
//                to idle at any point.
//  Ports       : clock        - system clock (posedge)
//                reset        - asynchronous active-high reset
//                timer_en     - level; rising edge starts, low aborts
//                one_sec      - BCD seconds units to load
//                ten_sec      - BCD seconds tens to load
//                one_min      - BCD minutes to load
//                pause        - level; freezes the countdown while running
//                rem_one_sec  - remaining seconds units (BCD)
//                rem_ten_sec  - remaining seconds tens (BCD)
//                rem_one_min  - remaining minutes (BCD)
//                running      - high while counting or paused
//                alarm        - high during the alarm phase (registered)
//                done         - one-cycle pulse on alarm entry (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module nap_countdown
  import nap_pkg::*;
#(
  parameter int CLK_HZ    = 1000,
  parameter int ALARM_SEC = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       timer_en,
  input  logic [3:0] one_sec,
  input  logic [3:0] ten_sec,
  input  logic [3:0] one_min,
  input  logic       pause,
  output logic [3:0] rem_one_sec,
  output logic [3:0] rem_ten_sec,
  output logic [3:0] rem_one_min,
  output logic       running,
  output logic       alarm,
  output logic       done
);

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

  nap_state_t state;
  nap_state_t next_state;

  logic       en_q;
  logic       start;
  logic       abort;
  logic       tick;
  logic       run_prescale;
  logic       clear_prescale;
  logic [3:0] alarm_cnt;
  logic       alarm_last;

  bcd_t       load_one;
  bcd_t       load_ten;
  bcd_t       load_min;
  logic       load_zero;

  bcd_t       dec_one;
  bcd_t       dec_ten;
  bcd_t       dec_min;
  logic       rem_zero;
  logic       rem_at_one;

  // --------------------------------------------------------------------------
  // Control decode
  // --------------------------------------------------------------------------
  assign start = timer_en & ~en_q;
  assign abort = ~timer_en & (state != ST_IDLE);

  assign load_one  = clamp_digit(one_sec, SEC_ONE_MAX);
  assign load_ten  = clamp_digit(ten_sec, SEC_TEN_MAX);
  assign load_min  = clamp_digit(one_min, MIN_MAX);
  assign load_zero = (load_one == 4'd0) && (load_ten == 4'd0) && (load_min == 4'd0);

  assign rem_zero   = (rem_one_sec == 4'd0) && (rem_ten_sec == 4'd0) && (rem_one_min == 4'd0);
  assign rem_at_one = (rem_one_sec == 4'd1) && (rem_ten_sec == 4'd0) && (rem_one_min == 4'd0);
  assign alarm_last = (alarm_cnt == ALARM_LAST);

  // The prescaler keeps counting in RUN even when pause is requested, so a
  // tick coinciding with pause still lands before the freeze. In IDLE it is
  // held at 0 so every load starts a full second.
  assign run_prescale   = (state == ST_RUN) || (state == ST_ALARM);
  assign clear_prescale = (state == ST_IDLE) || abort;

  nap_tick_gen #(
    .CLK_HZ (CLK_HZ)
  ) u_tick_gen (
    .clock (clock),
    .reset (reset),
    .run   (run_prescale),
    .clear (clear_prescale),
    .tick  (tick)
  );

  // --------------------------------------------------------------------------
  // BCD decrement of the remaining time (M:SS). Holds at 0:00.
  // --------------------------------------------------------------------------
  always_comb begin
    dec_one = rem_one_sec;
    dec_ten = rem_ten_sec;
    dec_min = rem_one_min;
    if (!rem_zero) begin
      if (rem_one_sec != 4'd0) begin
        dec_one = rem_one_sec - 4'd1;
      end else begin
        dec_one = SEC_ONE_MAX;
        if (rem_ten_sec != 4'd0) begin
          dec_ten = rem_ten_sec - 4'd1;
        end else begin
          dec_ten = SEC_TEN_MAX;
          dec_min = rem_one_min - 4'd1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state. Abort beats expiry, expiry beats pause.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = load_zero ? ST_ALARM : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (tick && rem_at_one) begin
          next_state = ST_ALARM;
        end else if (pause) begin
          next_state = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (!pause) begin
          next_state = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (abort) begin
          next_state = ST_IDLE;
        end else if (tick && alarm_last) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    running = (state == ST_RUN) || (state == ST_PAUSE);
  end

  // --------------------------------------------------------------------------
  // Datapath registers: edge detector, remaining time, alarm seconds,
  // registered alarm/done flags.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      en_q        <= 1'b0;
      rem_one_sec <= 4'd0;
      rem_ten_sec <= 4'd0;
      rem_one_min <= 4'd0;
      alarm_cnt   <= 4'd0;
      alarm       <= 1'b0;
      done        <= 1'b0;
    end else begin
      en_q  <= timer_en;
      alarm <= (next_state == ST_ALARM);
      done  <= (next_state == ST_ALARM) && (state != ST_ALARM);

      if (state == ST_ALARM && tick) begin
        alarm_cnt <= alarm_cnt + 4'd1;
      end else if (state != ST_ALARM) begin
        alarm_cnt <= 4'd0;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            rem_one_sec <= load_one;
            rem_ten_sec <= load_ten;
            rem_one_min <= load_min;
          end
        end
        ST_RUN: begin
          if (abort) begin
            rem_one_sec <= 4'd0;
            rem_ten_sec <= 4'd0;
            rem_one_min <= 4'd0;
          end else if (tick) begin
            rem_one_sec <= dec_one;
            rem_ten_sec <= dec_ten;
            rem_one_min <= dec_min;
          end
        end
        default: begin
          // PAUSE keeps the time unless aborted; ALARM always shows 0:00.
          if (abort || state == ST_ALARM) begin
            rem_one_sec <= 4'd0;
            rem_ten_sec <= 4'd0;
            rem_one_min <= 4'd0;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
